// File: rtl/imem_port_arbiter_if.sv
// Bundle of the two requester ports and the instruction-memory port served by
// imem_port_arbiter. The arbiter takes the slave view; requesters/memory the master view.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  m0_req, m0_addr, m1_req, m1_addr, mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
           mem_en, mem_addr, busy
  );

  modport master (
    output m0_req, m0_addr, m1_req, m1_addr, mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
           mem_en, mem_addr, busy
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, single-port instruction memory
// between the fetch port (0) and the loader/debug port (1), one access at a time.
module imem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int              CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_win_q, last_win_d;
  logic              owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              any_req, tie, winner;

  // On a tie the port that did not win the previous tie goes next.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    tie     = bus.m0_req & bus.m1_req;
    winner  = tie ? ~last_win_q : bus.m1_req;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_win_d = last_win_q;
    owner_d    = owner_q;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;
    gnt_d      = gnt_q;
    rvalid_d   = rvalid_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    case (state_q)
      S_IDLE, S_RESP: begin
        if (state_q == S_RESP) begin
          gnt_d    = 2'b00;
          rvalid_d = 2'b00;
          state_d  = S_IDLE;
        end
        if (any_req) begin
          state_d    = S_ISSUE;
          mem_en_d   = 1'b1;
          mem_addr_d = winner ? bus.m1_addr : bus.m0_addr;
          gnt_d      = winner ? 2'b10 : 2'b01;
          owner_d    = winner;
          if (tie) last_win_d = winner;
        end
      end
      S_ISSUE: begin
        mem_en_d = 1'b0;
        cnt_d    = CNT_LOAD;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q) rdata1_d = bus.mem_rdata;
          else         rdata0_d = bus.mem_rdata;
          rvalid_d = owner_q ? 2'b10 : 2'b01;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset drops any in-flight access; the requester has to ask again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_win_q <= 1'b1;
      owner_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_win_q <= last_win_d;
      owner_q    <= owner_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: one instance with MEM_LATENCY=1, one with 3,
// each fed by a memory model returning {16'hA000, addr[15:0]} after the latency.
module tb_imem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // Memory models: data is only valid exactly MEM_LATENCY cycles after mem_en.
  logic [31:0] a1 = '0;
  logic        v1 = 1'b0;
  logic [31:0] a3 [3];
  logic [2:0]  v3 = '0;
  always @(posedge clk) begin
    a1    <= if1.mem_addr;
    v1    <= if1.mem_en;
    a3[0] <= if3.mem_addr;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
    v3    <= {v3[1:0], if3.mem_en};
  end
  assign if1.mem_rdata = v1    ? {16'hA000, a1[15:0]}    : 32'hDEADBEEF;
  assign if3.mem_rdata = v3[2] ? {16'hA000, a3[2][15:0]} : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Invariants watched every cycle on both instances.
  logic pen1 = 1'b0, pen3 = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv1_gnt_onehot", {63'd0, if1.m0_gnt & if1.m1_gnt}, 64'd0);
      chk("inv1_men_b2b",    {63'd0, pen1 & if1.mem_en}, 64'd0);
      chk("inv1_rvalid_gnt", {62'd0, if1.m1_rvalid & ~if1.m1_gnt, if1.m0_rvalid & ~if1.m0_gnt}, 64'd0);
      chk("inv3_gnt_onehot", {63'd0, if3.m0_gnt & if3.m1_gnt}, 64'd0);
      chk("inv3_men_b2b",    {63'd0, pen3 & if3.mem_en}, 64'd0);
      chk("inv3_rvalid_gnt", {62'd0, if3.m1_rvalid & ~if3.m1_gnt, if3.m0_rvalid & ~if3.m0_gnt}, 64'd0);
    end
    pen1 <= if1.mem_en;
    pen3 <= if3.mem_en;
  end

  initial begin
    logic [31:0] exp_addr;
    if1.m0_req = 1'b0; if1.m0_addr = '0; if1.m1_req = 1'b0; if1.m1_addr = '0;
    if3.m0_req = 1'b0; if3.m0_addr = '0; if3.m1_req = 1'b0; if3.m1_addr = '0;

    // Reset state
    #3;
    chk("rst_outs1", {if1.m0_gnt, if1.m1_gnt, if1.m0_rvalid, if1.m1_rvalid, if1.mem_en, if1.busy}, 64'd0);
    chk("rst_outs3", {if3.m0_gnt, if3.m1_gnt, if3.m0_rvalid, if3.m1_rvalid, if3.mem_en, if3.busy}, 64'd0);
    chk("rst_data1", {if1.m0_rdata, if1.m1_rdata}, 64'd0);
    chk("rst_addr1", {32'd0, if1.mem_addr}, 64'd0);
    @(posedge clk); @(posedge clk); #3; rst_n = 1'b1;
    step();

    // Both requesting from reset: grants alternate 0,1,0,1
    if1.m0_req = 1'b1; if1.m0_addr = 32'h100;
    if1.m1_req = 1'b1; if1.m1_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_issue_gnt", {62'd0, if1.m1_gnt, if1.m0_gnt}, (k % 2) ? 64'd2 : 64'd1);
      chk("rr_issue_addr", {32'd0, if1.mem_addr}, (k % 2) ? 64'h200 : 64'h100);
      chk("rr_issue_men", {63'd0, if1.mem_en}, 64'd1);
      step();
      step();
      chk("rr_resp_rvalid", {62'd0, if1.m1_rvalid, if1.m0_rvalid}, (k % 2) ? 64'd2 : 64'd1);
      if (k % 2) chk("rr_resp_rdata1", {32'd0, if1.m1_rdata}, 64'hA0000200);
      else       chk("rr_resp_rdata0", {32'd0, if1.m0_rdata}, 64'hA0000100);
      if (k == 3) begin if1.m0_req = 1'b0; if1.m1_req = 1'b0; end
    end
    step();
    chk("rr_idle", {if1.m0_gnt, if1.m1_gnt, if1.busy, if1.mem_en}, 64'd0);

    // Single fetch at 0x10, latency 1
    if1.m0_req = 1'b1; if1.m0_addr = 32'h10;
    step();
    chk("one_men", {63'd0, if1.mem_en}, 64'd1);
    chk("one_maddr", {32'd0, if1.mem_addr}, 64'h10);
    chk("one_gnt_busy", {61'd0, if1.m0_gnt, if1.busy, if1.m0_rvalid}, 64'b110);
    if1.m0_req = 1'b0;
    step();
    chk("one_wait", {61'd0, if1.mem_en, if1.busy, if1.m0_rvalid}, 64'b010);
    step();
    chk("one_rvalid", {62'd0, if1.m0_rvalid, if1.busy}, 64'b10);
    chk("one_rdata", {32'd0, if1.m0_rdata}, 64'hA0000010);
    step();
    chk("one_after", {62'd0, if1.m0_rvalid, if1.m0_gnt}, 64'd0);
    chk("one_hold", {32'd0, if1.m0_rdata}, 64'hA0000010);

    // Held fetch, address changed in each RESP: one word every 3 cycles
    if1.m0_req = 1'b1; if1.m0_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      exp_addr = 32'(4 * k);
      step();
      chk("stream_issue", {61'd0, if1.mem_en, if1.m0_gnt, if1.m0_rvalid}, 64'b110);
      chk("stream_addr", {32'd0, if1.mem_addr}, {32'd0, exp_addr});
      step();
      chk("stream_wait", {62'd0, if1.mem_en, if1.m0_rvalid}, 64'd0);
      step();
      chk("stream_rvalid", {63'd0, if1.m0_rvalid}, 64'd1);
      chk("stream_rdata", {32'd0, if1.m0_rdata}, {32'd0, 16'hA000, exp_addr[15:0]});
      if (k == 2) if1.m0_req = 1'b0;
      else        if1.m0_addr = 32'(4 * (k + 1));
    end
    step();
    chk("stream_idle", {61'd0, if1.m0_gnt, if1.m0_rvalid, if1.busy}, 64'd0);

    // Loader drops req right after grant: access still completes
    if1.m1_req = 1'b1; if1.m1_addr = 32'h300;
    step();
    chk("drop_gnt", {62'd0, if1.m1_gnt, if1.mem_en}, 64'b11);
    chk("drop_addr", {32'd0, if1.mem_addr}, 64'h300);
    if1.m1_req = 1'b0;
    step();
    step();
    chk("drop_rvalid", {63'd0, if1.m1_rvalid}, 64'd1);
    chk("drop_rdata", {32'd0, if1.m1_rdata}, 64'hA0000300);
    step();
    chk("drop_idle", {60'd0, if1.m1_rvalid, if1.m1_gnt, if1.busy, if1.mem_en}, 64'd0);
    step();
    chk("drop_once", {63'd0, if1.m1_rvalid}, 64'd0);
    chk("drop_m0_kept", {32'd0, if1.m0_rdata}, 64'hA0000008);

    // Latency 3, loader request arriving during fetch WAIT
    if3.m0_req = 1'b1; if3.m0_addr = 32'h40;
    step();
    chk("l3_issue", {62'd0, if3.mem_en, if3.m0_gnt}, 64'b11);
    chk("l3_addr", {32'd0, if3.mem_addr}, 64'h40);
    if3.m0_req = 1'b0;
    step();
    if3.m1_req = 1'b1; if3.m1_addr = 32'h80;
    step();
    chk("l3_wait_hold", {61'd0, if3.m1_gnt, if3.mem_en, if3.busy}, 64'b001);
    step();
    chk("l3_no_early", {63'd0, if3.m0_rvalid}, 64'd0);
    step();
    chk("l3_rvalid", {61'd0, if3.m0_rvalid, if3.m0_gnt, if3.m1_gnt}, 64'b110);
    chk("l3_rdata", {32'd0, if3.m0_rdata}, 64'hA0000040);
    step();
    chk("l3_m1_issue", {60'd0, if3.mem_en, if3.m1_gnt, if3.m0_gnt, if3.m0_rvalid}, 64'b1100);
    chk("l3_m1_addr", {32'd0, if3.mem_addr}, 64'h80);
    if3.m1_req = 1'b0;
    step(); step(); step();
    chk("l3_m1_no_early", {63'd0, if3.m1_rvalid}, 64'd0);
    step();
    chk("l3_m1_rvalid", {63'd0, if3.m1_rvalid}, 64'd1);
    chk("l3_m1_rdata", {32'd0, if3.m1_rdata}, 64'hA0000080);
    step();
    chk("l3_idle", {61'd0, if3.m1_rvalid, if3.m1_gnt, if3.busy}, 64'd0);

    // Asynchronous reset in the middle of WAIT
    if3.m0_req = 1'b1; if3.m0_addr = 32'h44;
    step();
    step();
    chk("ar_in_wait", {62'd0, if3.busy, if3.m0_gnt}, 64'b11);
    if3.m0_req = 1'b0;
    #3; rst_n = 1'b0;
    #1;
    chk("ar_outs", {if3.m0_gnt, if3.m1_gnt, if3.m0_rvalid, if3.m1_rvalid, if3.mem_en, if3.busy}, 64'd0);
    chk("ar_data", {if3.m0_rdata, if3.m1_rdata}, 64'd0);
    chk("ar_addr", {32'd0, if3.mem_addr}, 64'd0);
    @(posedge clk); #3; rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("ar_no_rvalid", {62'd0, if3.m0_rvalid, if3.busy}, 64'd0);
    end
    if3.m0_req = 1'b1; if3.m0_addr = 32'h48;
    step();
    chk("ar_reissue", {62'd0, if3.mem_en, if3.m0_gnt}, 64'b11);
    chk("ar_readdr", {32'd0, if3.mem_addr}, 64'h48);
    if3.m0_req = 1'b0;
    step(); step(); step();
    chk("ar_pre_resp", {63'd0, if3.m0_rvalid}, 64'd0);
    step();
    chk("ar_rvalid", {63'd0, if3.m0_rvalid}, 64'd1);
    chk("ar_rdata", {32'd0, if3.m0_rdata}, 64'hA0000048);
    step();
    chk("ar_final_idle", {62'd0, if3.m0_rvalid, if3.busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
